// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction
// fetch and the load/store port. Load/store wins contention unless fetch has
// been starved for STARVE_MAX consecutive contended cycles. The owner of the
// single in-flight read is tracked so read data is returned to that owner only.
module mem_port_arbiter #(
  parameter int ADDR       = 16,
  parameter int W_DATA     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR-1:0]   if_addr_i,
  input  logic              if_flush_i,
  output logic              if_stall_o,
  output logic              if_v_o,
  output logic [W_DATA-1:0] if_data_o,
  input  logic              ls_req_i,
  input  logic              ls_write_i,
  input  logic [ADDR-1:0]   ls_addr_i,
  input  logic [W_DATA-1:0] ls_wdata_i,
  output logic              ls_stall_o,
  output logic              ls_ack_o,
  output logic              ls_v_o,
  output logic [W_DATA-1:0] ls_data_o,
  output logic [ADDR-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [W_DATA-1:0] mem_wdata_o,
  input  logic [W_DATA-1:0] mem_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_LS_RD = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            grant_ls, grant_if;

  // Pick at most one requester; fetch only beats load/store once starved.
  always_comb begin
    grant_ls = ls_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM));
    grant_if = if_req_i && !grant_ls;
  end

  // Owner and starvation counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next owner of the in-flight read and next starvation count.
  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_ls && !ls_write_i) begin
      owner_d = OWN_LS_RD;
    end
    if (!if_req_i || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_ls && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end
  end

  // Memory command, handshakes and read-data steering to the current owner.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_wdata_o = '0;
    ls_ack_o    = 1'b0;
    if_stall_o  = 1'b0;
    ls_stall_o  = 1'b0;
    if_v_o      = 1'b0;
    if_data_o   = '0;
    ls_v_o      = 1'b0;
    ls_data_o   = '0;
    if (grant_ls) begin
      mem_addr_o = ls_addr_i;
      ls_ack_o   = 1'b1;
      if_stall_o = if_req_i;
      if (ls_write_i) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = ls_wdata_i;
      end else begin
        mem_re_o = 1'b1;
      end
    end else if (grant_if) begin
      mem_addr_o = if_addr_i;
      mem_re_o   = 1'b1;
      ls_stall_o = ls_req_i;
    end
    if (owner_q == OWN_IF) begin
      if_v_o    = ~if_flush_i;
      if_data_o = mem_rdata_i;
    end
    if (owner_q == OWN_LS_RD) begin
      ls_v_o    = 1'b1;
      ls_data_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_mem_port_arbiter;

  localparam int ADDR       = 16;
  localparam int W_DATA     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              if_req_i;
  logic [ADDR-1:0]   if_addr_i;
  logic              if_flush_i;
  logic              if_stall_o;
  logic              if_v_o;
  logic [W_DATA-1:0] if_data_o;
  logic              ls_req_i;
  logic              ls_write_i;
  logic [ADDR-1:0]   ls_addr_i;
  logic [W_DATA-1:0] ls_wdata_i;
  logic              ls_stall_o;
  logic              ls_ack_o;
  logic              ls_v_o;
  logic [W_DATA-1:0] ls_data_o;
  logic [ADDR-1:0]   mem_addr_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [W_DATA-1:0] mem_wdata_o;
  logic [W_DATA-1:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  // Model state: who receives next cycle's read data (0 none, 1 fetch, 2 load)
  // and how many contended cycles fetch has lost in a row.
  int pendingReader;
  int lostInRow;
  bit expGrantIf;
  bit expGrantLs;

  mem_port_arbiter #(
    .ADDR(ADDR), .W_DATA(W_DATA), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_stall_o(if_stall_o), .if_v_o(if_v_o), .if_data_o(if_data_o),
    .ls_req_i(ls_req_i), .ls_write_i(ls_write_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_stall_o(ls_stall_o), .ls_ack_o(ls_ack_o),
    .ls_v_o(ls_v_o), .ls_data_o(ls_data_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [ADDR-1:0] ifAddr, input bit flush,
                               input bit lsReq, input bit write, input logic [ADDR-1:0] lsAddr,
                               input logic [W_DATA-1:0] wdata, input logic [W_DATA-1:0] rdata);
    if_req_i    = ifReq;
    if_addr_i   = ifAddr;
    if_flush_i  = flush;
    ls_req_i    = lsReq;
    ls_write_i  = write;
    ls_addr_i   = lsAddr;
    ls_wdata_i  = wdata;
    mem_rdata_i = rdata;
  endtask

  // Compare every output against the model in the middle of the cycle.
  task automatic checkOutput();
    logic [ADDR-1:0]   eAddr;
    logic [W_DATA-1:0] eIfData;
    logic [W_DATA-1:0] eLsData;
    @(negedge clk);
    expGrantLs = ls_req_i && !(if_req_i && lostInRow >= STARVE_MAX);
    expGrantIf = if_req_i && !expGrantLs;
    eAddr = expGrantLs ? ls_addr_i : (expGrantIf ? if_addr_i : '0);
    checkVal("mem_addr", 32'(mem_addr_o), 32'(eAddr));
    checkVal("mem_we", 32'(mem_we_o), 32'(expGrantLs && ls_write_i));
    checkVal("mem_re", 32'(mem_re_o), 32'((expGrantLs && !ls_write_i) || expGrantIf));
    if (mem_we_o || !(if_req_i || ls_req_i))
      checkVal("mem_wdata", mem_wdata_o, (expGrantLs && ls_write_i) ? ls_wdata_i : '0);
    checkVal("ls_ack", 32'(ls_ack_o), 32'(expGrantLs));
    checkVal("if_stall", 32'(if_stall_o), 32'(if_req_i && !expGrantIf));
    checkVal("ls_stall", 32'(ls_stall_o), 32'(ls_req_i && !expGrantLs));
    eIfData = (pendingReader == 1) ? mem_rdata_i : '0;
    eLsData = (pendingReader == 2) ? mem_rdata_i : '0;
    checkVal("if_v", 32'(if_v_o), 32'(pendingReader == 1 && !if_flush_i));
    checkVal("if_data", if_data_o, eIfData);
    checkVal("ls_v", 32'(ls_v_o), 32'(pendingReader == 2));
    checkVal("ls_data", ls_data_o, eLsData);
  endtask

  // Move the model across the next rising edge, then return just after it.
  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      pendingReader = 0;
      lostInRow     = 0;
    end else begin
      pendingReader = expGrantIf ? 1 : ((expGrantLs && !ls_write_i) ? 2 : 0);
      if (!if_req_i || expGrantIf) lostInRow = 0;
      else if (expGrantLs) lostInRow = (lostInRow + 1 > STARVE_MAX) ? STARVE_MAX : lostInRow + 1;
    end
    #1;
  endtask

  logic [W_DATA-1:0] rnd;

  initial begin
    pendingReader = 0;
    lostInRow     = 0;
    expGrantIf    = 0;
    expGrantLs    = 0;

    // Reset held two cycles with both requesters active.
    reset = 1'b0;
    applyStimulus(1, 16'h0100, 0, 1, 0, 16'h0200, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput();
    checkVal("rst_if_v", 32'(if_v_o), 32'd0);
    checkVal("rst_ls_v", 32'(ls_v_o), 32'd0);
    checkVal("rst_ls_ack", 32'(ls_ack_o), 32'd1);
    advance();

    // Idle cycle to drain the load granted above.
    applyStimulus(0, '0, 0, 0, 0, '0, '0, 32'hA5A5_0001);
    checkOutput();
    advance();

    // Fetch only, data returned next cycle.
    applyStimulus(1, 16'h0010, 0, 0, 0, '0, '0, '0);
    checkOutput();
    checkVal("fetch_re", 32'(mem_re_o), 32'd1);
    checkVal("fetch_addr", 32'(mem_addr_o), 32'h0010);
    advance();
    applyStimulus(0, '0, 0, 0, 0, '0, '0, 32'hDEAD_BEEF);
    checkOutput();
    checkVal("fetch_v", 32'(if_v_o), 32'd1);
    checkVal("fetch_data", if_data_o, 32'hDEAD_BEEF);
    advance();

    // Store completes in its grant cycle with no read response.
    applyStimulus(0, '0, 0, 1, 1, 16'h0020, 32'h1234_5678, '0);
    checkOutput();
    checkVal("store_we", 32'(mem_we_o), 32'd1);
    checkVal("store_ack", 32'(ls_ack_o), 32'd1);
    checkVal("store_wdata", mem_wdata_o, 32'h1234_5678);
    advance();
    applyStimulus(0, '0, 0, 0, 0, '0, '0, 32'h0BAD_0BAD);
    checkOutput();
    checkVal("store_no_v", 32'(ls_v_o), 32'd0);
    advance();

    // Both requesting for six cycles: fetch forced through on the fifth.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 16'h0040, 0, 1, 0, 16'h0080, '0, 32'(c));
      checkOutput();
      checkVal($sformatf("starve_ack%0d", c), 32'(ls_ack_o), 32'(c != 4));
      checkVal($sformatf("starve_ifst%0d", c), 32'(if_stall_o), 32'(c != 4));
      checkVal($sformatf("starve_lsst%0d", c), 32'(ls_stall_o), 32'(c == 4));
      advance();
    end

    // Fetch granted, flushed in the response cycle while a load is granted.
    applyStimulus(1, 16'h0300, 0, 0, 0, '0, '0, 32'h1111_1111);
    checkOutput();
    advance();
    applyStimulus(0, '0, 1, 1, 0, 16'h0400, '0, 32'h2222_2222);
    checkOutput();
    checkVal("flush_if_v", 32'(if_v_o), 32'd0);
    checkVal("flush_ld_ack", 32'(ls_ack_o), 32'd1);
    advance();
    applyStimulus(0, '0, 0, 0, 0, '0, '0, 32'h3333_3333);
    checkOutput();
    checkVal("flush_ls_v", 32'(ls_v_o), 32'd1);
    checkVal("flush_ls_data", ls_data_o, 32'h3333_3333);
    advance();

    // Load granted, then reset asserted during its response cycle.
    applyStimulus(0, '0, 0, 1, 0, 16'h0500, '0, '0);
    checkOutput();
    advance();
    reset = 1'b0;
    applyStimulus(0, '0, 0, 0, 0, '0, '0, 32'h4444_4444);
    checkOutput();
    advance();
    reset = 1'b1;
    applyStimulus(1, 16'h0600, 0, 1, 0, 16'h0700, '0, 32'h5555_5555);
    checkOutput();
    checkVal("rst_drop_ls_v", 32'(ls_v_o), 32'd0);
    checkVal("rst_cnt_ls_wins", 32'(ls_ack_o), 32'd1);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      reset = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom),
                    32'($urandom), rnd);
      checkOutput();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
